lag_test_sequencer: RTL and testbench

- Controls one input-lag measurement cycle, alternating with the flashing test fields drawn by the video generator.
- Arms on the generator's starttrigger pulse and times the delay until the photo sensor sees the white field.
- Collects SAMPLES valid measurements and computes last/min/max/average lag in 0.1 ms ticks.
- Hands the result set to the lag-display formatter over a valid/ready handshake.

---
 rtl/lag_test_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_lag_test_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_test_sequencer.sv
// lag_test_sequencer: times the delay from a video-generator field-start
// trigger to the photo sensor seeing the white field. It collects SAMPLES
// measurements and reports last/min/max/average lag in 0.1 ms ticks over
// a valid/ready handshake.
module lag_test_sequencer #(
  parameter int TICK_DIV      = 14850,
  parameter int DEBOUNCE      = 16,
  parameter int SAMPLES       = 8,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        starttrigger,
  input  logic        sensor,
  input  logic        result_ready,
  output logic        result_valid,
  output logic [15:0] lag_last,
  output logic [15:0] lag_min,
  output logic [15:0] lag_max,
  output logic [15:0] lag_avg,
  output logic [7:0]  timeout_count,
  output logic        busy
);

  localparam int SHIFT   = $clog2(SAMPLES);
  localparam int SUM_W   = 16 + SHIFT;
  localparam int IDX_W   = $clog2(SAMPLES + 1);
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [IDX_W-1:0]   IDX_FULL   = IDX_W'(SAMPLES);
  localparam logic [15:0]        TMO_LIMIT  = 16'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    MEASURE = 3'd2,
    HOLDOFF = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state, state_next;

  logic               sync1, sync2;
  logic               det;
  logic [DEB_W-1:0]   deb_cnt;
  logic [PRESC_W-1:0] presc;
  logic [15:0]        lag_cnt;
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   sample_idx;
  logic [15:0]        min_trk, max_trk;

  logic start, take_sample, take_timeout, latch_result, accept, abort;

  // Two-flop synchronizer for the asynchronous sensor level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  // Debouncer: det follows sync2 only after DEBOUNCE equal consecutive values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      det     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == det) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      det     <= sync2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and single-cycle datapath strobes.
  always_comb begin
    state_next   = state;
    start        = 1'b0;
    take_sample  = 1'b0;
    take_timeout = 1'b0;
    latch_result = 1'b0;
    accept       = 1'b0;
    abort        = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      abort      = 1'b1;
    end else begin
      case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          // A trigger while the screen still reads bright is meaningless.
          if (starttrigger && !det) begin
            state_next = MEASURE;
            start      = 1'b1;
          end
        end
        MEASURE: begin
          // A detection on the timeout cycle still counts as a sample.
          if (det) begin
            state_next  = HOLDOFF;
            take_sample = 1'b1;
          end else if (lag_cnt >= TMO_LIMIT) begin
            state_next   = ARMED;
            take_timeout = 1'b1;
          end
        end
        HOLDOFF: begin
          if (!det) begin
            if (sample_idx == IDX_FULL) begin
              state_next   = DONE;
              latch_result = 1'b1;
            end else begin
              state_next = ARMED;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state_next = ARMED;
            accept     = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Tick prescaler and saturating lag counter, restarted by each accepted trigger.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc   <= '0;
      lag_cnt <= '0;
    end else if (start) begin
      presc   <= '0;
      lag_cnt <= '0;
    end else if (state == MEASURE) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        if (lag_cnt != 16'hFFFF) lag_cnt <= lag_cnt + 16'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // Set accumulation, result latching, timeout tally and registered status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum           <= '0;
      sample_idx    <= '0;
      min_trk       <= 16'hFFFF;
      max_trk       <= '0;
      lag_last      <= '0;
      lag_min       <= '0;
      lag_max       <= '0;
      lag_avg       <= '0;
      timeout_count <= '0;
      result_valid  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (abort || accept) begin
        sum           <= '0;
        sample_idx    <= '0;
        min_trk       <= 16'hFFFF;
        max_trk       <= '0;
        timeout_count <= '0;
      end else begin
        if (take_sample) begin
          lag_last   <= lag_cnt;
          sum        <= sum + SUM_W'(lag_cnt);
          sample_idx <= sample_idx + 1'b1;
          if (lag_cnt < min_trk) min_trk <= lag_cnt;
          if (lag_cnt > max_trk) max_trk <= lag_cnt;
        end
        if (take_timeout && timeout_count != 8'hFF)
          timeout_count <= timeout_count + 8'd1;
      end
      if (latch_result) begin
        lag_avg <= 16'(sum >> SHIFT);
        lag_min <= min_trk;
        lag_max <= max_trk;
      end
      result_valid <= (state_next == DONE);
      busy         <= (state_next == MEASURE) || (state_next == HOLDOFF);
    end
  end

endmodule

// File: tb/tb_lag_test_sequencer.sv
// Bench for lag_test_sequencer: a timestamp-based reference model checked
// against the DUT every cycle, plus directed literal expectations.
module tb_lag_test_sequencer;

  localparam int TD  = 4;
  localparam int DB  = 2;
  localparam int NS  = 4;
  localparam int TMO = 20;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        starttrigger = 1'b0;
  logic        sensor = 1'b0;
  logic        result_ready = 1'b0;
  logic        result_valid;
  logic [15:0] lag_last, lag_min, lag_max, lag_avg;
  logic [7:0]  timeout_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  lag_test_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE(DB), .SAMPLES(NS), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .starttrigger(starttrigger), .sensor(sensor), .result_ready(result_ready),
    .result_valid(result_valid), .lag_last(lag_last), .lag_min(lag_min),
    .lag_max(lag_max), .lag_avg(lag_avg), .timeout_count(timeout_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 armed, 2 measuring, 3 holdoff, 4 result pending.
  int  cyc = 0;
  int  ph = 0;
  int  trig_cyc = 0;
  bit  det_m = 0;
  bit  hist [0:63];
  int  smp[$];
  int  m_last = 0, m_min = 0, m_max = 0, m_avg = 0, m_tc = 0;
  bit  det_pre, flip;
  int  lagv, s, mn, mx;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc = 0; ph = 0; trig_cyc = 0; det_m = 0;
      for (int i = 0; i < 64; i++) hist[i] = 0;
      smp.delete();
      m_last = 0; m_min = 0; m_max = 0; m_avg = 0; m_tc = 0;
    end else begin
      cyc++;
      det_pre = det_m;
      // Detector flips once the synchronized sensor (two edges late) has
      // disagreed with it for DB consecutive edges.
      flip = 1;
      for (int i = 1; i <= DB; i++) if (hist[i] == det_m) flip = 0;
      if (flip) det_m = !det_m;
      for (int i = 63; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sensor;
      lagv = (cyc - 1 - trig_cyc) / TD;
      if (lagv > 65535) lagv = 65535;
      if (!enable) begin
        ph = 0; smp.delete(); m_tc = 0;
      end else begin
        case (ph)
          0: ph = 1;
          1: if (starttrigger && !det_pre) begin ph = 2; trig_cyc = cyc; end
          2: begin
            if (det_pre) begin
              m_last = lagv; smp.push_back(lagv); ph = 3;
            end else if (lagv >= TMO) begin
              if (m_tc < 255) m_tc++;
              ph = 1;
            end
          end
          3: if (!det_pre) begin
            if (smp.size() == NS) begin
              s = 0; mn = 65535; mx = 0;
              foreach (smp[i]) begin
                s += smp[i];
                if (smp[i] < mn) mn = smp[i];
                if (smp[i] > mx) mx = smp[i];
              end
              m_avg = s / NS; m_min = mn; m_max = mx; ph = 4;
            end else ph = 1;
          end
          4: if (result_ready) begin ph = 1; smp.delete(); m_tc = 0; end
          default: ph = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    chk("valid", int'(result_valid), int'(ph == 4));
    chk("busy", int'(busy), int'(ph == 2 || ph == 3));
    chk("lag_last", int'(lag_last), m_last);
    chk("lag_min", int'(lag_min), m_min);
    chk("lag_max", int'(lag_max), m_max);
    chk("lag_avg", int'(lag_avg), m_avg);
    chk("timeout_count", int'(timeout_count), m_tc);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Trigger, optional retrigger/glitch, then a stable bright level such that
  // the detector rises exactly `delay` cycles after the trigger edge.
  task automatic measure(input int delay, input int retrig, input int glitch);
    starttrigger = 1'b1;
    step(1);
    starttrigger = 1'b0;
    for (int k = 1; k <= delay - 4; k++) begin
      starttrigger = (k == retrig);
      sensor = (glitch != 0 && k == glitch);
      step(1);
    end
    starttrigger = 1'b0;
    sensor = 1'b1;
    step(6);
    chk("busy_in_holdoff", int'(busy), 1);
    sensor = 1'b0;
    step(6);
  endtask

  initial begin
    step(3);
    chk("reset_valid", int'(result_valid), 0);
    chk("reset_lag_min", int'(lag_min), 0);
    chk("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    enable = 1'b1;
    step(3);

    // Basic sample and full set.
    measure(41, 0, 0);
    chk("t1_lag_last", int'(lag_last), 10);
    chk("t1_valid", int'(result_valid), 0);
    chk("t1_busy", int'(busy), 0);
    measure(20, 0, 0);
    measure(60, 0, 0);
    measure(8, 0, 0);
    chk("t2_valid", int'(result_valid), 1);
    chk("t2_last", int'(lag_last), 2);
    chk("t2_min", int'(lag_min), 2);
    chk("t2_max", int'(lag_max), 15);
    chk("t2_avg", int'(lag_avg), 8);
    step(5);
    chk("t2_valid_held", int'(result_valid), 1);
    result_ready = 1'b1;
    step(1);
    result_ready = 1'b0;
    chk("t2_valid_drop", int'(result_valid), 0);

    // Timeouts and saturation.
    starttrigger = 1'b1; step(1); starttrigger = 1'b0;
    step(85);
    chk("t3_tc1", int'(timeout_count), 1);
    chk("t3_busy", int'(busy), 0);
    for (int r = 0; r < 299; r++) begin
      starttrigger = 1'b1; step(1); starttrigger = 1'b0;
      step(82);
    end
    chk("t3_tc_sat", int'(timeout_count), 255);

    // Trigger while bright is ignored.
    sensor = 1'b1; step(6);
    starttrigger = 1'b1; step(1); starttrigger = 1'b0;
    step(2);
    chk("t4_no_measure", int'(busy), 0);
    sensor = 1'b0; step(6);
    // Retrigger does not restart; glitch is rejected.
    measure(41, 10, 0);
    chk("t4_retrig_last", int'(lag_last), 10);
    measure(60, 0, 20);
    chk("t5_glitch_last", int'(lag_last), 15);

    // Enable drop mid-measure after two samples.
    starttrigger = 1'b1; step(1); starttrigger = 1'b0;
    step(10);
    enable = 1'b0; step(1);
    chk("t6_idle_busy", int'(busy), 0);
    chk("t6_tc_clear", int'(timeout_count), 0);
    enable = 1'b1; step(2);
    measure(16, 0, 0);
    measure(24, 0, 0);
    measure(32, 0, 0);
    chk("t6_not_yet", int'(result_valid), 0);
    measure(36, 0, 0);
    chk("t6_valid", int'(result_valid), 1);
    chk("t6_min", int'(lag_min), 4);
    chk("t6_max", int'(lag_max), 9);
    chk("t6_avg", int'(lag_avg), 6);
    result_ready = 1'b1; step(1); result_ready = 1'b0;

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      starttrigger = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) sensor = !sensor;
      result_ready = ($urandom_range(0, 3) == 0);
      enable = ($urandom_range(0, 599) != 0);
      step(1);
    end

    // Drain, then reset asynchronously while a result is pending.
    starttrigger = 1'b0; sensor = 1'b0; enable = 1'b1; result_ready = 1'b1;
    step(100);
    result_ready = 1'b0;
    enable = 1'b0; step(1);
    enable = 1'b1; step(2);
    measure(30, 0, 0);
    measure(12, 0, 0);
    measure(50, 0, 0);
    measure(25, 0, 0);
    chk("t7_valid", int'(result_valid), 1);
    chk("t7_avg", int'(lag_avg), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_rst_valid", int'(result_valid), 0);
    chk("t7_rst_last", int'(lag_last), 0);
    chk("t7_rst_min", int'(lag_min), 0);
    chk("t7_rst_max", int'(lag_max), 0);
    chk("t7_rst_avg", int'(lag_avg), 0);
    chk("t7_rst_busy", int'(busy), 0);
    step(2);
    reset_n = 1'b1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
